pipe_cpu_fwd: RTL and testbench
===============================

# pipe_cpu_fwd

Parametrised four-stage in-order pipelined CPU core: IF, ID, EX, WB. It adds several features the first-generation core lacked:
- a loadable instruction memory;
- a configurable register count and data width;
- write-back-only register updates with EX bypassing;
- branches with flush;
- a HALT state and a retire counter.

It is the standalone execution core for directed program tests and the base for later cache and I/O work.

## Interface
- WIDTH, 32, datapath and register width (≥ 8)
- DEPTH, 16, instruction-memory words (power of 2, ≥ 2); AW = $clog2(DEPTH)
- NREGS, 8, architectural registers (2..16); R0 reads zero
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- run  in  1  pipeline advances only when 1
- prog_we  in  1  instruction-memory write strobe
- prog_addr  in  AW  write address
- prog_data  in  16  instruction word
- dbg_sel  in  4  register-file debug read index
- dbg_data  out  WIDTH  combinational regfile[dbg_sel]; 0 if dbg_sel = 0 or dbg_sel ≥ NREGS
- pc  out  AW  current fetch address
- halted  out  1  HALT has executed
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_rd  out  4  destination of the retired instruction
- wb_data  out  WIDTH  result of the retired instruction
- retire_cnt  out  32  retired-instruction count, wraps at 2^32

## Operation
- Instruction format: op[15:12], rd[11:8], rs[7:4], rt[3:0], imm[7:0].
- Opcodes:
  - 0 NOP
  - 1 LOADI: rd ← zero-extended imm
  - 2 ADD: rd ← rs + rt
  - 3 SUB: rd ← rs − rt
  - 4 AND
  - 5 OR
  - 6 BEQZ: if R[rd] = 0 then pc ← imm[AW-1:0]
  - 7 JMP: pc ← imm[AW-1:0]
  - F HALT
  - 8–E are treated as NOP.
- Arithmetic is modulo 2^WIDTH; SUB wraps (0 − 1 = all ones).
- Register file:
  - written only in WB;
  - writes with rd = 0 or rd ≥ NREGS are dropped;
  - reads of index 0 or index ≥ NREGS return 0.
- Operands are read in EX from the register file. If the instruction currently in WB writes the same register (nonzero, < NREGS), that result is bypassed instead. Back-to-back dependencies therefore never stall.
- Instruction-memory contents are undefined until written and are not cleared by reset. prog_we writes at the clock edge regardless of run/halted. A fetch in the same cycle as a write to the same address returns the old word.
- PC increments by 1 and wraps from DEPTH−1 to 0.
- Branches and JMP resolve in EX. When taken, the instructions in IF and ID are squashed to bubbles and pc loads the target. This costs a 2-cycle penalty. A not-taken BEQZ costs nothing.
- HALT in EX:
  - sets halted;
  - squashes IF and ID;
  - lets the instruction already in WB complete.
- Once halted, the pipeline freezes until reset, and the HALT itself retires.
- Retirement:
  - every non-bubble instruction reaching WB retires, including NOP, branches and HALT;
  - retiring drives wb_valid, wb_rd, wb_data and increments retire_cnt;
  - non-writing instructions report wb_rd = rd field and wb_data = 0.
- Squashed bubbles never retire.
- run = 0 freezes every stage, pc and the counters. No writes or retirements occur while frozen.

## Timing
- Reset values:
  - pc = 0;
  - all stages hold bubbles;
  - halted = 0, wb_valid = 0, wb_rd = 0, wb_data = 0, retire_cnt = 0;
  - registers R1..NREGS−1 = 0.
- Reset has priority over run and applies mid-program: the in-flight instructions are discarded and no write-back follows.
- Stage flow, with run = 1 from the first edge after reset and counting edges from 1:
  - edge 1 loads IF with imem[0];
  - edge 2 loads ID;
  - edge 3 loads the EX result;
  - edge 4 writes the register file.
- wb_valid for instruction k is high in the cycle after edge 4 + k (no branches).
- Throughput is 1 instruction per cycle. A taken branch inserts exactly 2 bubbles. HALT at address h stops fetch, so addresses above h are never retired.
- dbg_data reflects a write-back in the cycle after the writing edge.

## Test plan
- **Basic program.** Program LOADI R1,5; LOADI R2,10; ADD R3,R1,R2; SUB R4,R3,R1; HALT. Expect:
  - wb pulses on 5 consecutive cycles;
  - R3 = 15, R4 = 10;
  - retire_cnt = 5, halted = 1;
  - pc frozen afterwards.
- **Forwarding chain.** LOADI R1,1 followed by ADD R1,R1,R1 ×4. Expect R1 = 16, no bubbles, and wb_data sequence 1, 2, 4, 8, 16.
- **Branch flush.** LOADI R1,0; BEQZ R1,5; LOADI R2,7; LOADI R2,8; NOP; LOADI R3,9; HALT. Expect:
  - R2 = 0, R3 = 9;
  - exactly 2 missing retire cycles after the BEQZ.
- **Register edges.** With NREGS = 8: LOADI R0,3 → R0 reads 0. LOADI R9,3 → dropped and dbg_data(9) = 0. SUB R5,R0,R1 with R1 = 1 → R5 = 0xFFFFFFFF.
- **Run/wrap.** Drop run for 3 cycles mid-program → state unchanged and the results are identical to an uninterrupted run. A program of NOPs without HALT → pc wraps 15 → 0.
- **Reset mid-run.** Assert reset during the ADD's EX cycle. Expect:
  - no wb pulse for the ADD;
  - pc = 0, retire_cnt = 0;
  - the program reruns to the same final registers.

Source files
------------

// File: rtl/pipe_cpu_fwd.sv
// Four-stage (IF, ID, EX, WB) in-order CPU core with EX bypassing from the write-back stage,
// branch flush, HALT and a retire counter. Instruction memory is loaded through prog_*.
module pipe_cpu_fwd #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int NREGS = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [15:0]      prog_data,
    input  logic [3:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data,
    output logic [AW-1:0]    pc,
    output logic             halted,
    output logic             wb_valid,
    output logic [3:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic [31:0]      retire_cnt
);

    localparam int RIW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [3:0] OP_LOADI = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_BEQZ  = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    logic [15:0]      imem [DEPTH];
    logic [WIDTH-1:0] regs [NREGS];

    logic             if_valid, id_valid, ex_valid;
    logic [15:0]      if_instr, id_instr;
    logic             ex_we;
    logic [3:0]       ex_rd;
    logic [WIDTH-1:0] ex_data;

    logic [3:0]       id_op, id_rd, id_rs, id_rt;
    logic [7:0]       id_imm;
    logic [WIDTH-1:0] rf_rd, rf_rs, rf_rt;
    logic [WIDTH-1:0] opd_rd, opd_rs, opd_rt;
    logic             ex_we_n, taken, halt_ex, flush;
    logic [WIDTH-1:0] ex_data_n;
    logic [AW-1:0]    target;

    // Index 0 is hard-wired zero; indices beyond the implemented file are ignored.
    function automatic logic reg_ok(input logic [3:0] idx);
        return (idx != 4'd0) && (int'(idx) < NREGS);
    endfunction

    assign id_op  = id_instr[15:12];
    assign id_rd  = id_instr[11:8];
    assign id_rs  = id_instr[7:4];
    assign id_rt  = id_instr[3:0];
    assign id_imm = id_instr[7:0];

    assign rf_rd = reg_ok(id_rd) ? regs[id_rd[RIW-1:0]] : '0;
    assign rf_rs = reg_ok(id_rs) ? regs[id_rs[RIW-1:0]] : '0;
    assign rf_rt = reg_ok(id_rt) ? regs[id_rt[RIW-1:0]] : '0;

    // The result waiting in the WB stage is not yet in the register file, so take it directly.
    assign opd_rd = (ex_valid && ex_we && reg_ok(ex_rd) && ex_rd == id_rd) ? ex_data : rf_rd;
    assign opd_rs = (ex_valid && ex_we && reg_ok(ex_rd) && ex_rd == id_rs) ? ex_data : rf_rs;
    assign opd_rt = (ex_valid && ex_we && reg_ok(ex_rd) && ex_rd == id_rt) ? ex_data : rf_rt;

    assign dbg_data = reg_ok(dbg_sel) ? regs[dbg_sel[RIW-1:0]] : '0;

    always_comb begin
        ex_we_n   = 1'b0;
        ex_data_n = '0;
        taken     = 1'b0;
        halt_ex   = 1'b0;
        target    = id_imm[AW-1:0];
        if (id_valid) begin
            case (id_op)
                OP_LOADI: begin
                    ex_we_n   = 1'b1;
                    ex_data_n = WIDTH'(id_imm);
                end
                OP_ADD: begin
                    ex_we_n   = 1'b1;
                    ex_data_n = opd_rs + opd_rt;
                end
                OP_SUB: begin
                    ex_we_n   = 1'b1;
                    ex_data_n = opd_rs - opd_rt;
                end
                OP_AND: begin
                    ex_we_n   = 1'b1;
                    ex_data_n = opd_rs & opd_rt;
                end
                OP_OR: begin
                    ex_we_n   = 1'b1;
                    ex_data_n = opd_rs | opd_rt;
                end
                OP_BEQZ: taken   = (opd_rd == '0);
                OP_JMP:  taken   = 1'b1;
                OP_HALT: halt_ex = 1'b1;
                default: ;
            endcase
        end
        flush = taken | halt_ex;
    end

    // Instruction memory is deliberately not reset; a same-address fetch sees the old word.
    always_ff @(posedge clk) begin
        if (prog_we)
            imem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= '0;
            if_valid   <= 1'b0;
            id_valid   <= 1'b0;
            ex_valid   <= 1'b0;
            if_instr   <= '0;
            id_instr   <= '0;
            ex_we      <= 1'b0;
            ex_rd      <= '0;
            ex_data    <= '0;
            halted     <= 1'b0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            retire_cnt <= '0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (!run) begin
            wb_valid <= 1'b0;
        end else begin
            wb_valid <= ex_valid;
            if (ex_valid) begin
                wb_rd      <= ex_rd;
                wb_data    <= ex_data;
                retire_cnt <= retire_cnt + 32'd1;
                if (ex_we && reg_ok(ex_rd))
                    regs[ex_rd[RIW-1:0]] <= ex_data;
            end
            // After HALT only the WB stage drains so the HALT itself retires.
            if (halted) begin
                ex_valid <= 1'b0;
            end else begin
                if (halt_ex)
                    pc <= pc;
                else if (taken)
                    pc <= target;
                else
                    pc <= pc + AW'(1);
                if_valid <= !flush;
                if_instr <= imem[pc];
                id_valid <= if_valid && !flush;
                id_instr <= if_instr;
                ex_valid <= id_valid;
                ex_we    <= ex_we_n;
                ex_rd    <= id_rd;
                ex_data  <= ex_data_n;
                halted   <= halt_ex;
            end
        end
    end

endmodule

// File: tb/tb_pipe_cpu_fwd.sv
// Directed program tests for pipe_cpu_fwd: hand-computed retire streams, register results and pc.
module tb_pipe_cpu_fwd;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic [3:0]  dbg_sel = '0;
    logic [31:0] dbg_data;
    logic [3:0]  pc;
    logic        halted;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] retire_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          log_cyc[$];
    logic [3:0]  log_rd[$];
    logic [31:0] log_data[$];

    pipe_cpu_fwd #(.WIDTH(32), .DEPTH(16), .NREGS(8)) dut (
        .clk(clk), .reset(reset), .run(run),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data),
        .pc(pc), .halted(halted),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wb_valid) begin
            log_cyc.push_back(cyc);
            log_rd.push_back(wb_rd);
            log_data.push_back(wb_data);
        end
    end

    // Holds reset while writing all 16 words, then leaves the core idle with run = 0.
    task automatic load_prog(input logic [15:0] p [16]);
        @(negedge clk);
        run   = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            prog_we   = 1'b1;
            prog_addr = 4'(i);
            prog_data = p[i];
            @(negedge clk);
        end
        prog_we = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        log_cyc.delete();
        log_rd.delete();
        log_data.delete();
    endtask

    task automatic read_reg(input logic [3:0] idx, output logic [31:0] v);
        dbg_sel = idx;
        #1;
        v = dbg_data;
    endtask

    task automatic wait_halt(input int limit);
        int n = 0;
        while (!halted && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_timeout: halted=%b after %0d cycles, required 1", halted, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (pc !== 4'd0 || halted !== 1'b0 || wb_valid !== 1'b0 || wb_rd !== 4'd0 ||
            wb_data !== 32'd0 || retire_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: pc=%0d halted=%b wb_valid=%b wb_rd=%0d wb_data=%0h retire=%0d, required all 0",
                     pc, halted, wb_valid, wb_rd, wb_data, retire_cnt);
        end
        for (int r = 1; r < 8; r++) begin
            read_reg(4'(r), v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL reset_reg R%0d: got %0h, required 0", r, v);
            end
        end
    endtask

    task automatic test_basic();
        logic [15:0] p [16] = '{16'h1105, 16'h120A, 16'h2312, 16'h3431, 16'hF000,
                                16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [31:0] exp_d [5] = '{32'd5, 32'd10, 32'd15, 32'd10, 32'd0};
        logic [3:0]  exp_r [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        logic [31:0] v;
        int c0;
        load_prog(p);
        run = 1'b1;
        c0 = cyc;
        wait_halt(40);
        checks++;
        if (log_cyc.size() != 5) begin
            errors++;
            $display("FAIL basic_retire_count_log: got %0d pulses, required 5", log_cyc.size());
        end
        for (int i = 0; i < 5 && i < log_cyc.size(); i++) begin
            checks++;
            if (log_data[i] !== exp_d[i] || log_rd[i] !== exp_r[i] || log_cyc[i] != c0 + 4 + i) begin
                errors++;
                $display("FAIL basic_wb[%0d]: rd=%0d data=%0d cyc=%0d, required rd=%0d data=%0d cyc=%0d",
                         i, log_rd[i], log_data[i], log_cyc[i] - c0, exp_r[i], exp_d[i], 4 + i);
            end
        end
        read_reg(4'd3, v);
        checks++;
        if (v !== 32'd15) begin errors++; $display("FAIL basic_R3: got %0d, required 15", v); end
        read_reg(4'd4, v);
        checks++;
        if (v !== 32'd10) begin errors++; $display("FAIL basic_R4: got %0d, required 10", v); end
        checks++;
        if (retire_cnt !== 32'd5 || halted !== 1'b1 || pc !== 4'd6) begin
            errors++;
            $display("FAIL basic_final: retire=%0d halted=%b pc=%0d, required 5 1 6", retire_cnt, halted, pc);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (pc !== 4'd6 || retire_cnt !== 32'd5 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_frozen: pc=%0d retire=%0d wb_valid=%b, required 6 5 0", pc, retire_cnt, wb_valid);
        end
    endtask

    task automatic test_forwarding();
        logic [15:0] p [16] = '{16'h1101, 16'h2111, 16'h2111, 16'h2111, 16'h2111, 16'hF000,
                                16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [31:0] exp_d [6] = '{32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd0};
        logic [31:0] v;
        int c0;
        load_prog(p);
        run = 1'b1;
        c0 = cyc;
        wait_halt(40);
        checks++;
        if (log_cyc.size() != 6) begin
            errors++;
            $display("FAIL fwd_retire_count_log: got %0d pulses, required 6", log_cyc.size());
        end
        for (int i = 0; i < 6 && i < log_cyc.size(); i++) begin
            checks++;
            if (log_data[i] !== exp_d[i] || log_cyc[i] != c0 + 4 + i) begin
                errors++;
                $display("FAIL fwd_wb[%0d]: data=%0d cyc=%0d, required data=%0d cyc=%0d",
                         i, log_data[i], log_cyc[i] - c0, exp_d[i], 4 + i);
            end
        end
        read_reg(4'd1, v);
        checks++;
        if (v !== 32'd16) begin errors++; $display("FAIL fwd_R1: got %0d, required 16", v); end
    endtask

    task automatic test_branch_flush();
        logic [15:0] p [16] = '{16'h1100, 16'h6105, 16'h1207, 16'h1208, 16'h0000, 16'h1309, 16'hF000,
                                16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        int          exp_c [4] = '{4, 5, 8, 9};
        logic [3:0]  exp_r [4] = '{4'd1, 4'd1, 4'd3, 4'd0};
        logic [31:0] exp_d [4] = '{32'd0, 32'd0, 32'd9, 32'd0};
        logic [31:0] v;
        int c0;
        load_prog(p);
        run = 1'b1;
        c0 = cyc;
        wait_halt(40);
        checks++;
        if (log_cyc.size() != 4) begin
            errors++;
            $display("FAIL br_retire_count_log: got %0d pulses, required 4", log_cyc.size());
        end
        for (int i = 0; i < 4 && i < log_cyc.size(); i++) begin
            checks++;
            if (log_data[i] !== exp_d[i] || log_rd[i] !== exp_r[i] || log_cyc[i] != c0 + exp_c[i]) begin
                errors++;
                $display("FAIL br_wb[%0d]: rd=%0d data=%0d cyc=%0d, required rd=%0d data=%0d cyc=%0d",
                         i, log_rd[i], log_data[i], log_cyc[i] - c0, exp_r[i], exp_d[i], exp_c[i]);
            end
        end
        read_reg(4'd2, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL br_R2: got %0d, required 0", v); end
        read_reg(4'd3, v);
        checks++;
        if (v !== 32'd9) begin errors++; $display("FAIL br_R3: got %0d, required 9", v); end
        checks++;
        if (retire_cnt !== 32'd4 || pc !== 4'd8) begin
            errors++;
            $display("FAIL br_final: retire=%0d pc=%0d, required 4 8", retire_cnt, pc);
        end
    endtask

    task automatic test_reg_edges();
        logic [15:0] p [16] = '{16'h1101, 16'h1903, 16'h1003, 16'h3501, 16'hF000,
                                16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [31:0] v;
        load_prog(p);
        run = 1'b1;
        wait_halt(40);
        read_reg(4'd0, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL reg_R0: got %0h, required 0", v); end
        read_reg(4'd9, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL reg_R9: got %0h, required 0", v); end
        read_reg(4'd1, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL reg_R1: got %0h, required 1", v); end
        read_reg(4'd5, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reg_R5_sub_wrap: got %0h, required ffffffff", v); end
        checks++;
        if (log_rd.size() < 2 || log_rd[1] !== 4'd9 || retire_cnt !== 32'd5) begin
            errors++;
            $display("FAIL reg_retire: pulses=%0d retire=%0d, required second wb_rd=9 and retire 5",
                     log_rd.size(), retire_cnt);
        end
    endtask

    task automatic test_run_wrap();
        logic [15:0] p [16] = '{16'h1105, 16'h120A, 16'h2312, 16'h3431, 16'hF000,
                                16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [15:0] z [16] = '{default: 16'h0000};
        logic [31:0] exp_d [5] = '{32'd5, 32'd10, 32'd15, 32'd10, 32'd0};
        logic [31:0] v;
        load_prog(p);
        run = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (pc !== 4'd6 || retire_cnt !== 32'd3) begin
            errors++;
            $display("FAIL run_before_stall: pc=%0d retire=%0d, required 6 3", pc, retire_cnt);
        end
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (pc !== 4'd6 || retire_cnt !== 32'd3 || wb_valid !== 1'b0 || halted !== 1'b0) begin
                errors++;
                $display("FAIL run_stall[%0d]: pc=%0d retire=%0d wb_valid=%b halted=%b, required 6 3 0 0",
                         i, pc, retire_cnt, wb_valid, halted);
            end
        end
        run = 1'b1;
        wait_halt(40);
        checks++;
        if (log_data.size() != 5) begin
            errors++;
            $display("FAIL run_log: got %0d pulses, required 5", log_data.size());
        end
        for (int i = 0; i < 5 && i < log_data.size(); i++) begin
            checks++;
            if (log_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL run_wb[%0d]: got %0d, required %0d", i, log_data[i], exp_d[i]);
            end
        end
        read_reg(4'd4, v);
        checks++;
        if (v !== 32'd10 || retire_cnt !== 32'd5 || pc !== 4'd6) begin
            errors++;
            $display("FAIL run_final: R4=%0d retire=%0d pc=%0d, required 10 5 6", v, retire_cnt, pc);
        end
        load_prog(z);
        run = 1'b1;
        repeat (15) @(negedge clk);
        checks++;
        if (pc !== 4'd15) begin errors++; $display("FAIL wrap_pc15: got %0d, required 15", pc); end
        @(negedge clk);
        checks++;
        if (pc !== 4'd0 || retire_cnt !== 32'd13 || halted !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pc0: pc=%0d retire=%0d halted=%b, required 0 13 0", pc, retire_cnt, halted);
        end
        run = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] p [16] = '{16'h1105, 16'h120A, 16'h2312, 16'h3431, 16'hF000,
                                16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [31:0] v;
        load_prog(p);
        run = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        read_reg(4'd1, v);
        checks++;
        if (pc !== 4'd0 || retire_cnt !== 32'd0 || wb_valid !== 1'b0 || halted !== 1'b0 || v !== 32'd0) begin
            errors++;
            $display("FAIL midreset_state: pc=%0d retire=%0d wb_valid=%b halted=%b R1=%0d, required all 0",
                     pc, retire_cnt, wb_valid, halted, v);
        end
        checks++;
        if (log_cyc.size() != 1) begin
            errors++;
            $display("FAIL midreset_no_add_wb: got %0d pulses, required 1", log_cyc.size());
        end
        reset = 1'b0;
        wait_halt(40);
        read_reg(4'd3, v);
        checks++;
        if (v !== 32'd15) begin errors++; $display("FAIL midreset_R3: got %0d, required 15", v); end
        read_reg(4'd4, v);
        checks++;
        if (v !== 32'd10 || retire_cnt !== 32'd5 || log_cyc.size() != 6) begin
            errors++;
            $display("FAIL midreset_rerun: R4=%0d retire=%0d pulses=%0d, required 10 5 6",
                     v, retire_cnt, log_cyc.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forwarding();
        test_branch_flush();
        test_reg_edges();
        test_run_wrap();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
